// File: rtl/mux_n_1_rr.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mux_n_1_rr : registered N:1 selector, indexed or round-robin, valid/ready
// Revision 1.0
// ---------------------------------------------------------------------------
module mux_n_1_rr #(
  parameter int data_width_param = 32,
  parameter int num_inputs_param = 4,
  parameter int sel_width_param  = $clog2(num_inputs_param)
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic [num_inputs_param*data_width_param-1:0] in_data,
  input  logic [num_inputs_param-1:0]                  in_valid,
  output logic [num_inputs_param-1:0]                  in_ready,
  input  logic                                         mode,
  input  logic [sel_width_param-1:0]                   sel,
  output logic [data_width_param-1:0]                  out_data,
  output logic [sel_width_param-1:0]                   out_sel,
  output logic                                         out_valid,
  input  logic                                         out_ready
);

  logic [sel_width_param-1:0]  ptr;
  logic                        load_en;
  logic                        grant_any;
  logic [sel_width_param-1:0]  grant_idx;
  logic [num_inputs_param-1:0] grant;
  logic [data_width_param-1:0] grant_word;
  logic                        hi_found;
  logic                        lo_found;
  logic [sel_width_param-1:0]  hi_idx;
  logic [sel_width_param-1:0]  lo_idx;

  assign load_en = ~out_valid | out_ready;

  // Round-robin: lowest valid channel above ptr, else wrap to lowest valid overall.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    hi_found  = 1'b0;
    lo_found  = 1'b0;
    hi_idx    = '0;
    lo_idx    = '0;
    for (int j = num_inputs_param - 1; j >= 0; j--) begin
      if (in_valid[j]) begin
        lo_found = 1'b1;
        lo_idx   = sel_width_param'(j);
        if (sel_width_param'(j) > ptr) begin
          hi_found = 1'b1;
          hi_idx   = sel_width_param'(j);
        end
      end
    end
    if (mode) begin
      if (hi_found) begin
        grant_any = 1'b1;
        grant_idx = hi_idx;
      end else if (lo_found) begin
        grant_any = 1'b1;
        grant_idx = lo_idx;
      end
    end else begin
      // Matching only real channel numbers makes out-of-range sel grant nothing.
      for (int j = 0; j < num_inputs_param; j++) begin
        if (sel == sel_width_param'(j) && in_valid[j]) begin
          grant_any = 1'b1;
          grant_idx = sel;
        end
      end
    end
  end

  always_comb begin
    grant      = '0;
    grant_word = '0;
    for (int j = 0; j < num_inputs_param; j++) begin
      if (grant_any && grant_idx == sel_width_param'(j)) begin
        grant[j]   = 1'b1;
        grant_word = in_data[j*data_width_param +: data_width_param];
      end
    end
  end

  assign in_ready = grant & {num_inputs_param{load_en & ~rst}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= sel_width_param'(num_inputs_param - 1);
    end else if (load_en) begin
      if (grant_any) begin
        out_valid <= 1'b1;
        out_data  <= grant_word;
        out_sel   <= grant_idx;
        if (mode) begin
          ptr <= grant_idx;
        end
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mux_n_1_rr.sv
`default_nettype none
// Directed testbench for mux_n_1_rr: N=4 main instance plus an N=3 instance.
module tb_mux_n_1_rr;
  logic         clk = 1'b0;
  logic         rst = 1'b1;

  logic [127:0] in_data;
  logic [3:0]   in_valid;
  logic [3:0]   in_ready;
  logic         mode;
  logic [1:0]   sel;
  logic [31:0]  out_data;
  logic [1:0]   out_sel;
  logic         out_valid;
  logic         out_ready;

  logic [95:0]  in_data3;
  logic [2:0]   in_valid3;
  logic [2:0]   in_ready3;
  logic         mode3;
  logic [1:0]   sel3;
  logic [31:0]  out_data3;
  logic [1:0]   out_sel3;
  logic         out_valid3;
  logic         out_ready3;

  int checks   = 0;
  int failures = 0;

  logic [31:0] words [4] = '{32'habcd, 32'h1234, 32'ha1b1, 32'hc2d2};

  always #5 clk = ~clk;

  mux_n_1_rr #(.data_width_param(32), .num_inputs_param(4)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .sel(sel), .out_data(out_data), .out_sel(out_sel),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  mux_n_1_rr #(.data_width_param(32), .num_inputs_param(3)) dut3 (
    .clk(clk), .rst(rst), .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
    .mode(mode3), .sel(sel3), .out_data(out_data3), .out_sel(out_sel3),
    .out_valid(out_valid3), .out_ready(out_ready3)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    mode      = 1'b1;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || out_sel !== 2'd0) begin
      failures++;
      $display("FAIL reset_outputs: valid=%b data=%h sel=%0d, want 0/0/0", out_valid, out_data, out_sel);
    end
    checks++;
    if (in_ready !== 4'b0000) begin
      failures++;
      $display("FAIL reset_in_ready: got %b want 0000", in_ready);
    end
    rst = 1'b0;
  endtask

  task automatic test_indexed_sweep();
    mode      = 1'b0;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      #1;
      checks++;
      if (in_ready !== 4'(1 << s)) begin
        failures++;
        $display("FAIL idx_in_ready[%0d]: got %b want %b", s, in_ready, 4'(1 << s));
      end
      step();
      checks++;
      if (out_valid !== 1'b1 || out_data !== words[s] || out_sel !== 2'(s)) begin
        failures++;
        $display("FAIL idx_out[%0d]: valid=%b data=%h sel=%0d, want 1/%h/%0d",
                 s, out_valid, out_data, out_sel, words[s], s);
      end
    end
  endtask

  task automatic test_rr_fair();
    test_reset();
    for (int k = 0; k < 8; k++) begin
      step();
      checks++;
      if (out_valid !== 1'b1 || out_sel !== 2'(k % 4) || out_data !== words[k % 4]) begin
        failures++;
        $display("FAIL rr_fair[%0d]: valid=%b sel=%0d data=%h, want 1/%0d/%h",
                 k, out_valid, out_sel, out_data, k % 4, words[k % 4]);
      end
    end
  endtask

  task automatic test_rr_sparse();
    logic [1:0] exp_sel [4] = '{2'd1, 2'd3, 2'd1, 2'd3};
    test_reset();
    in_valid = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if (out_valid !== 1'b1 || out_sel !== exp_sel[k]) begin
        failures++;
        $display("FAIL rr_sparse[%0d]: valid=%b sel=%0d, want 1/%0d", k, out_valid, out_sel, exp_sel[k]);
      end
    end
    in_valid = 4'b0000;
    step();
    checks++;
    if (out_valid !== 1'b0 || out_sel !== 2'd3 || out_data !== 32'hc2d2) begin
      failures++;
      $display("FAIL rr_drain: valid=%b sel=%0d data=%h, want 0/3/c2d2", out_valid, out_sel, out_data);
    end
  endtask

  task automatic test_backpressure();
    test_reset();
    mode     = 1'b0;
    sel      = 2'd1;
    in_valid = 4'b1111;
    step();
    out_ready = 1'b0;
    sel       = 2'd2;
    in_data[63:32] = 32'h5555;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (in_ready !== 4'b0000) begin
        failures++;
        $display("FAIL bp_in_ready[%0d]: got %b want 0000", k, in_ready);
      end
      step();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'h1234 || out_sel !== 2'd1) begin
        failures++;
        $display("FAIL bp_hold[%0d]: valid=%b data=%h sel=%0d, want 1/1234/1", k, out_valid, out_data, out_sel);
      end
      sel = (k == 0) ? 2'd3 : 2'd2;
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 4'b0100) begin
      failures++;
      $display("FAIL bp_release_ready: got %b want 0100", in_ready);
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'ha1b1 || out_sel !== 2'd2) begin
      failures++;
      $display("FAIL bp_release_out: valid=%b data=%h sel=%0d, want 1/a1b1/2", out_valid, out_data, out_sel);
    end
    in_data[63:32] = 32'h1234;
  endtask

  task automatic test_out_of_range();
    mode3      = 1'b0;
    out_ready3 = 1'b1;
    in_valid3  = 3'b111;
    sel3       = 2'd2;
    step();
    checks++;
    if (out_valid3 !== 1'b1 || out_data3 !== 32'h3333 || out_sel3 !== 2'd2) begin
      failures++;
      $display("FAIL n3_load: valid=%b data=%h sel=%0d, want 1/3333/2", out_valid3, out_data3, out_sel3);
    end
    sel3 = 2'd3;
    #1;
    checks++;
    if (in_ready3 !== 3'b000) begin
      failures++;
      $display("FAIL n3_oor_ready: got %b want 000", in_ready3);
    end
    step();
    checks++;
    if (out_valid3 !== 1'b0) begin
      failures++;
      $display("FAIL n3_oor_valid: got %b want 0", out_valid3);
    end
    sel3      = 2'd1;
    in_valid3 = 3'b101;
    #1;
    checks++;
    if (in_ready3 !== 3'b000) begin
      failures++;
      $display("FAIL n3_invalid_ready: got %b want 000", in_ready3);
    end
    step();
    checks++;
    if (out_valid3 !== 1'b0 || out_sel3 !== 2'd2) begin
      failures++;
      $display("FAIL n3_invalid_out: valid=%b sel=%0d, want 0/2", out_valid3, out_sel3);
    end
  endtask

  task automatic test_async_reset();
    test_reset();
    mode      = 1'b1;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    step();
    step();
    checks++;
    if (out_valid !== 1'b1 || out_sel !== 2'd1) begin
      failures++;
      $display("FAIL areset_pre: valid=%b sel=%0d, want 1/1", out_valid, out_sel);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || out_sel !== 2'd0 || in_ready !== 4'b0000) begin
      failures++;
      $display("FAIL areset_async: valid=%b data=%h sel=%0d rdy=%b, want 0/0/0/0000",
               out_valid, out_data, out_sel, in_ready);
    end
    step();
    rst = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b1 || out_sel !== 2'd0 || out_data !== 32'habcd) begin
      failures++;
      $display("FAIL areset_first: valid=%b sel=%0d data=%h, want 1/0/abcd", out_valid, out_sel, out_data);
    end
  endtask

  initial begin
    in_data    = {32'hc2d2, 32'ha1b1, 32'h1234, 32'habcd};
    in_valid   = '0;
    mode       = 1'b0;
    sel        = '0;
    out_ready  = 1'b1;
    in_data3   = {32'h3333, 32'h2222, 32'h1111};
    in_valid3  = '0;
    mode3      = 1'b0;
    sel3       = '0;
    out_ready3 = 1'b1;

    test_reset();
    test_indexed_sweep();
    test_rr_fair();
    test_rr_sparse();
    test_backpressure();
    test_out_of_range();
    test_async_reset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire
